// File: rtl/stack_calc_pkg.sv
// rtl/stack_calc_pkg.sv - opcode and FSM state types for the stack calculator
package stack_calc_pkg;

   typedef enum logic [2:0] {
      OP_CLEAR = 3'd0,
      OP_PUSH  = 3'd1,
      OP_POP   = 3'd2,
      OP_ADD   = 3'd3,
      OP_SUB   = 3'd4
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ_B = 3'd1,
      S_READ_A = 3'd2,
      S_CAPT   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - single-port stack storage, sync write and 1-cycle sync read
module stack_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 128
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   addr,
   input  logic [DATA_W-1:0]          wdata,
   output logic [DATA_W-1:0]          rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage array carries no reset; rdata always reflects the address of the previous cycle
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/stack_calc_engine.sv
// rtl/stack_calc_engine.sv - RAM-backed stack calculator with push/pop/add/sub/clear
module stack_calc_engine
   import stack_calc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 128,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              rsp_flag,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   state_t             state, state_next;
   op_t                op_q;
   logic [DATA_W-1:0]  data_q;
   logic [DATA_W-1:0]  res_q;
   logic [DATA_W-1:0]  b_q;
   logic               err_q;
   logic               flag_q;

   logic               accept;
   logic               cmd_err;
   logic               ram_we;
   logic [AW-1:0]      ram_addr;
   logic [DATA_W-1:0]  ram_wdata;
   logic [DATA_W-1:0]  ram_rdata;
   logic [DATA_W:0]    alu_res;

   assign cmd_ready = (state == S_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign rsp_valid = (state == S_DONE);
   assign rsp_data  = res_q;
   assign rsp_err   = err_q;
   assign rsp_flag  = flag_q;

   // Reject commands the current stack occupancy cannot serve, and undefined opcodes
   always_comb begin
      cmd_err = 1'b1;
      case (cmd_op)
         OP_CLEAR: cmd_err = 1'b0;
         OP_PUSH:  cmd_err = full;
         OP_POP:   cmd_err = empty;
         OP_ADD,
         OP_SUB:   cmd_err = (count < CNT_W'(2));
         default:  cmd_err = 1'b1;
      endcase
   end

   // ALU: A is the RAM read of the second-from-top entry, B the latched top; MSB is carry/borrow
   always_comb begin
      alu_res = {1'b0, ram_rdata} + {1'b0, b_q};
      if (op_q == OP_SUB) begin
         alu_res = {1'b0, ram_rdata} - {1'b0, b_q};
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus RAM address/write control for the current state
   always_comb begin
      state_next = state;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_wdata  = alu_res[DATA_W-1:0];
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (cmd_err || cmd_op == OP_CLEAR) begin
                  state_next = S_DONE;
               end else if (cmd_op == OP_PUSH) begin
                  state_next = S_WRITE;
               end else begin
                  state_next = S_READ_B;
               end
            end
         end
         S_READ_B: begin
            ram_addr   = count[AW-1:0] - AW'(1);
            state_next = (op_q == OP_POP) ? S_CAPT : S_READ_A;
         end
         S_READ_A: begin
            ram_addr   = count[AW-1:0] - AW'(2);
            state_next = S_WRITE;
         end
         S_CAPT: begin
            state_next = S_DONE;
         end
         S_WRITE: begin
            ram_we     = 1'b1;
            state_next = S_DONE;
            if (op_q == OP_PUSH) begin
               ram_addr  = count[AW-1:0];
               ram_wdata = data_q;
            end else begin
               ram_addr  = count[AW-1:0] - AW'(2);
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Command latch, occupancy counter, result/flag registers and B operand capture
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_q   <= OP_CLEAR;
         data_q <= '0;
         count  <= '0;
         res_q  <= '0;
         b_q    <= '0;
         err_q  <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q   <= op_t'(cmd_op);
                  data_q <= cmd_data;
                  err_q  <= cmd_err;
                  flag_q <= 1'b0;
                  if (!cmd_err && cmd_op == OP_CLEAR) begin
                     count <= '0;
                     res_q <= '0;
                  end
               end
            end
            S_READ_A: begin
               b_q <= ram_rdata;
            end
            S_CAPT: begin
               res_q <= ram_rdata;
               count <= count - CNT_W'(1);
            end
            S_WRITE: begin
               if (op_q == OP_PUSH) begin
                  res_q <= data_q;
                  count <= count + CNT_W'(1);
               end else begin
                  res_q  <= alu_res[DATA_W-1:0];
                  flag_q <= alu_res[DATA_W];
                  count  <= count - CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   stack_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_stack_calc_engine.sv
// tb/tb_stack_calc_engine.sv - directed self-checking bench for stack_calc_engine
module tb_stack_calc_engine;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              rsp_flag;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;

   int n_cmp = 0;
   int n_bad = 0;

   stack_calc_engine #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rsp_flag  (rsp_flag),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one command and check the completion; busy cycles keep a CLEAR offered to prove it is ignored
   task automatic do_cmd(input string tag, input logic [2:0] op, input logic [7:0] d,
                         input int lat, input logic err, input logic [7:0] rd,
                         input logic fl, input int cnt);
      int   n;
      logic seen;
      logic busy_ready;
      @(negedge clk);
      check({tag, "/ready"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      n = 0;
      seen = 1'b0;
      busy_ready = 1'b0;
      while (!seen && n < 10) begin
         @(negedge clk);
         n++;
         if (rsp_valid) begin
            seen = 1'b1;
            cmd_valid = 1'b0;
         end else begin
            if (cmd_ready) busy_ready = 1'b1;
            cmd_op = 3'd0;
         end
      end
      cmd_valid = 1'b0;
      check({tag, "/latency"}, 32'(n), 32'(lat));
      check({tag, "/err"}, 32'(rsp_err), 32'(err));
      check({tag, "/data"}, 32'(rsp_data), 32'(rd));
      check({tag, "/flag"}, 32'(rsp_flag), 32'(fl));
      check({tag, "/count"}, 32'(count), 32'(cnt));
      check({tag, "/busy_ready"}, 32'(busy_ready), 32'd0);
   endtask

   initial begin
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_data  = '0;
      repeat (3) @(negedge clk);
      check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst/rsp_err", 32'(rsp_err), 32'd0);
      check("rst/rsp_flag", 32'(rsp_flag), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("rst/ready", 32'(cmd_ready), 32'd1);
      check("rst/empty", 32'(empty), 32'd1);
      check("rst/full", 32'(full), 32'd0);
      check("rst/count", 32'(count), 32'd0);
      check("rst/data", 32'(rsp_data), 32'd0);

      // Basic add
      do_cmd("push05", 3'd1, 8'h05, 2, 1'b0, 8'h05, 1'b0, 1);
      do_cmd("push03", 3'd1, 8'h03, 2, 1'b0, 8'h03, 1'b0, 2);
      do_cmd("add08",  3'd3, 8'h00, 4, 1'b0, 8'h08, 1'b0, 1);
      // Carry and borrow
      do_cmd("pushF0", 3'd1, 8'hF0, 2, 1'b0, 8'hF0, 1'b0, 2);
      do_cmd("push20", 3'd1, 8'h20, 2, 1'b0, 8'h20, 1'b0, 3);
      do_cmd("add_cy", 3'd3, 8'h00, 4, 1'b0, 8'h10, 1'b1, 2);
      do_cmd("push11", 3'd1, 8'h11, 2, 1'b0, 8'h11, 1'b0, 3);
      do_cmd("sub_bw", 3'd4, 8'h00, 4, 1'b0, 8'hFF, 1'b1, 2);
      do_cmd("clear1", 3'd0, 8'h00, 1, 1'b0, 8'h00, 1'b0, 0);
      // Fill, overflow, drain
      do_cmd("fill1", 3'd1, 8'h01, 2, 1'b0, 8'h01, 1'b0, 1);
      do_cmd("fill2", 3'd1, 8'h02, 2, 1'b0, 8'h02, 1'b0, 2);
      do_cmd("fill3", 3'd1, 8'h03, 2, 1'b0, 8'h03, 1'b0, 3);
      do_cmd("fill4", 3'd1, 8'h04, 2, 1'b0, 8'h04, 1'b0, 4);
      check("fill/full", 32'(full), 32'd1);
      do_cmd("ovf",  3'd1, 8'h55, 1, 1'b1, 8'h04, 1'b0, 4);
      do_cmd("pop4", 3'd2, 8'h00, 3, 1'b0, 8'h04, 1'b0, 3);
      check("pop4/full", 32'(full), 32'd0);
      do_cmd("pop3", 3'd2, 8'h00, 3, 1'b0, 8'h03, 1'b0, 2);
      do_cmd("pop2", 3'd2, 8'h00, 3, 1'b0, 8'h02, 1'b0, 1);
      do_cmd("pop1", 3'd2, 8'h00, 3, 1'b0, 8'h01, 1'b0, 0);
      check("drain/empty", 32'(empty), 32'd1);
      // Error cases
      do_cmd("pop_empty", 3'd2, 8'h00, 1, 1'b1, 8'h01, 1'b0, 0);
      do_cmd("push09", 3'd1, 8'h09, 2, 1'b0, 8'h09, 1'b0, 1);
      do_cmd("push04", 3'd1, 8'h04, 2, 1'b0, 8'h04, 1'b0, 2);
      do_cmd("sub_nb", 3'd4, 8'h00, 4, 1'b0, 8'h05, 1'b0, 1);
      do_cmd("add_one", 3'd3, 8'h00, 1, 1'b1, 8'h05, 1'b0, 1);
      do_cmd("illegal6", 3'd6, 8'h00, 1, 1'b1, 8'h05, 1'b0, 1);
      // Clear
      do_cmd("push07", 3'd1, 8'h07, 2, 1'b0, 8'h07, 1'b0, 2);
      do_cmd("clear2", 3'd0, 8'h00, 1, 1'b0, 8'h00, 1'b0, 0);
      // Reset during READ_A of an ADD
      do_cmd("pushA1", 3'd1, 8'hA1, 2, 1'b0, 8'hA1, 1'b0, 1);
      do_cmd("pushA2", 3'd1, 8'hA2, 2, 1'b0, 8'hA2, 1'b0, 2);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("abort/rd_b_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("abort/rd_a_ready", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("abort/in_reset_valid", 32'(rsp_valid), 32'd0);
      end
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("abort/post_valid", 32'(rsp_valid), 32'd0);
      end
      check("abort/count", 32'(count), 32'd0);
      check("abort/ready", 32'(cmd_ready), 32'd1);
      check("abort/empty", 32'(empty), 32'd1);
      check("abort/data", 32'(rsp_data), 32'd0);
      do_cmd("push2A", 3'd1, 8'h2A, 2, 1'b0, 8'h2A, 1'b0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stack_calc_engine.md
STACK_CALC_ENGINE -- requirements
Module: stack_calc_engine

Interface
REQ-001 Parameter DATA_W, default 8: operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DEPTH, default 128: stack capacity in entries; SHALL be >= 2.
REQ-003 Derived localparam CNT_W = $clog2(DEPTH+1), and AW = $clog2(DEPTH).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  engine accepts a command; high only in IDLE.
REQ-008 cmd_op  in  3  opcode: CLEAR=0, PUSH=1, POP=2, ADD=3, SUB=4; values 5-7 are illegal.
REQ-009 cmd_data  in  DATA_W  PUSH operand.
REQ-010 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-011 rsp_data  out  DATA_W  result register res_q.
REQ-012 rsp_err  out  1  command rejected; valid with rsp_valid.
REQ-013 rsp_flag  out  1  ADD carry-out or SUB borrow; valid with rsp_valid.
REQ-014 count  out  CNT_W  current number of entries.
REQ-015 full/empty  out  1 each  count==DEPTH / count==0.

Function
REQ-016 Accept: cmd_valid && cmd_ready on cycle T; the opcode and data SHALL be latched, and the cycle count below is measured from T.
REQ-017 FSM states: IDLE, READ_B, READ_A, CAPT, WRITE, DONE; DONE SHALL always return to IDLE.
REQ-018 PUSH path: IDLE->WRITE->DONE; WRITE stores cmd_data at RAM[count], sets res_q=cmd_data, count+1; rsp_valid at T+2.
REQ-019 POP path: IDLE->READ_B->CAPT->DONE; READ_B reads addr count-1; CAPT sets res_q=rdata, count-1; rsp_valid at T+3.
REQ-020 ADD/SUB path: IDLE->READ_B->READ_A->WRITE->DONE.
REQ-021 ADD/SUB READ_B: reads addr count-1.
REQ-022 ADD/SUB READ_A: latches B=rdata, reads addr count-2.
REQ-023 ADD/SUB WRITE: A=rdata; res_q=A+B (ADD) or A-B (SUB) modulo 2^DATA_W; writes res_q to RAM[count-2]; count-1; rsp_valid at T+4.
REQ-024 rsp_flag SHALL equal the carry-out of the DATA_W-bit ADD, or 1 when A<B unsigned (SUB); it SHALL be 0 for all other commands.
REQ-025 CLEAR: IDLE->DONE; count=0, res_q=0; RAM contents SHALL NOT be modified; rsp_valid at T+1.
REQ-026 Error cases go IDLE->DONE with rsp_err=1, rsp_valid at T+1, and no change to count, res_q or RAM: PUSH when full; POP when empty; ADD/SUB when count<2; illegal opcode.
REQ-027 cmd_ready SHALL be 0 from T+1 until the cycle after the DONE cycle; cmd_valid while not ready SHALL be ignored.
REQ-028 Back-to-back commands: a command may be accepted in the IDLE cycle immediately after DONE.
REQ-029 Reads SHALL be issued only at addresses < count, so the address never wraps; PUSH at count==DEPTH-1 SHALL fill the last entry and set full.

Reset
REQ-030 While reset==0 at a rising edge, the engine SHALL enter: state=IDLE, count=0, res_q=0, B=0, rsp_valid=0, rsp_err=0, rsp_flag=0.
REQ-031 Reset outputs: after reset, cmd_ready=1, empty=1, full=0.
REQ-032 Reset mid-operation SHALL abort the command with no rsp_valid; a partially written RAM entry is don't-care.

Structure
REQ-033 Package stack_calc_pkg SHALL hold the opcode enum (op_t, 3 bits) and the FSM state enum (state_t).
REQ-034 Sub-module stack_ram (parametrised DATA_W, DEPTH): single-port RAM with synchronous write, synchronous 1-cycle read and a write-enable; there is no reset on the storage array.
REQ-035 No tri-state buses inside the block; read and write data paths SHALL be separate.

Verification (DATA_W=8, DEPTH=4)
REQ-036 Reset, then PUSH 0x05, PUSH 0x03, ADD -> responses at T+2, T+2, T+4; final rsp_data=0x08, flag=0, count=1.
REQ-037 PUSH 0xF0, PUSH 0x20, ADD -> rsp_data=0x10, flag=1. Then PUSH 0x11, SUB -> rsp_data=0xFF, flag=1.
REQ-038 PUSH x4 (0x01..0x04) -> full=1; fifth PUSH -> rsp_err=1 at T+1, count=4. POP x4 -> rsp_data 0x04,0x03,0x02,0x01; empty=1.
REQ-039 Empty stack: POP -> err=1; after one PUSH, ADD -> err=1, count=1; opcode 6 -> err=1.
REQ-040 PUSH 0x07, then CLEAR -> count=0, rsp_data=0x00 at T+1; reset asserted during READ_A of an ADD -> no rsp_valid, count=0, cmd_ready=1 after release.
